pack_cmd_ctrl: RTL and testbench

PACK_CMD_CTRL -- requirements
Module: pack_cmd_ctrl

---
 rtl/pack_cmd_ctrl_pkg.sv | 29 ++
 rtl/pack_cmd_ctrl_if.sv | 33 +++
 rtl/pack_gap_timer.sv | 34 +++
 rtl/pack_cmd_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pack_cmd_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pack_cmd_ctrl_pkg.sv
// Shared types and constants for the UART command-pack controller.
// Holds the FSM encoding, ack codes, control-byte layout and pack length.
package pack_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_WAIT_CH,
        ST_ISSUE,
        ST_ACK
    } state_e;

    localparam logic [7:0] ACK_OK = 8'h06;
    localparam logic [7:0] ACK_NG = 8'h15;

    localparam int CTRL_CH_LSB     = 0;
    localparam int CTRL_CH_W       = 4;
    localparam int CTRL_REPEAT_BIT = 4;
    localparam int CTRL_STOP_BIT   = 5;
    localparam int CTRL_RSV_LSB    = 6;
    localparam int CTRL_RSV_W      = 2;

    // control byte + output pattern + freq pattern + low period + high period
    function automatic int pack_num(input int data_bit);
        return (data_bit / 8) * 2 + 3;
    endfunction

endpackage

// File: rtl/pack_cmd_ctrl_if.sv
// Byte input, channel-busy input and config/ack outputs of pack_cmd_ctrl.
// Pure wiring bundle; no flow control beyond the rx tick and busy vector.
interface pack_cmd_ctrl_if #(
    parameter int DATA_BIT = 32,
    parameter int CH_NUM   = 16
);
    logic [7:0]          data_i;
    logic                rx_done_tick_i;
    logic [CH_NUM-1:0]   ch_busy_i;
    logic                cfg_valid_o;
    logic [3:0]          cfg_ch_o;
    logic                cfg_stop_o;
    logic                cfg_repeat_o;
    logic [DATA_BIT-1:0] cfg_output_o;
    logic [DATA_BIT-1:0] cfg_freq_o;
    logic [7:0]          cfg_low_o;
    logic [7:0]          cfg_high_o;
    logic                tx_start_o;
    logic [7:0]          tx_data_o;
    logic                busy_o;

    modport slave (
        input  data_i, rx_done_tick_i, ch_busy_i,
        output cfg_valid_o, cfg_ch_o, cfg_stop_o, cfg_repeat_o, cfg_output_o,
               cfg_freq_o, cfg_low_o, cfg_high_o, tx_start_o, tx_data_o, busy_o
    );

    modport master (
        output data_i, rx_done_tick_i, ch_busy_i,
        input  cfg_valid_o, cfg_ch_o, cfg_stop_o, cfg_repeat_o, cfg_output_o,
               cfg_freq_o, cfg_low_o, cfg_high_o, tx_start_o, tx_data_o, busy_o
    );
endinterface

// File: rtl/pack_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles since the last clear.
// expire_o is combinational and high in the TIMEOUT_CLK-th enabled cycle.
module pack_gap_timer #(
    parameter int TIMEOUT_CLK = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT_CLK + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CLK - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pack_cmd_ctrl.sv
// Assembles a UART command pack, validates it, waits for the target channel and issues one config strobe plus ack byte.
// Last byte to cfg_valid_o is 3 cycles with the channel idle; holds in WAIT_CH while the channel is busy, bytes outside COLLECT are dropped.
module pack_cmd_ctrl
    import pack_cmd_ctrl_pkg::*;
#(
    parameter int DATA_BIT    = 32,
    parameter int CH_NUM      = 16,
    parameter int TIMEOUT_CLK = 100000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    pack_cmd_ctrl_if.slave  bus
);
    localparam int NB       = DATA_BIT / 8;
    localparam int PACK_NUM = pack_num(DATA_BIT);
    localparam int CW       = $clog2(PACK_NUM + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7:0]          pack_q [PACK_NUM];
    logic [7:0]          pack_d [PACK_NUM];
    logic                cfg_valid_q, cfg_valid_d;
    logic [3:0]          cfg_ch_q, cfg_ch_d;
    logic                cfg_stop_q, cfg_stop_d;
    logic                cfg_repeat_q, cfg_repeat_d;
    logic [DATA_BIT-1:0] cfg_output_q, cfg_output_d;
    logic [DATA_BIT-1:0] cfg_freq_q, cfg_freq_d;
    logic [7:0]          cfg_low_q, cfg_low_d;
    logic [7:0]          cfg_high_q, cfg_high_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;

    logic [7:0]          ctrl;
    logic [3:0]          ch;
    logic                stop_bit, repeat_bit;
    logic [1:0]          rsv;
    logic [DATA_BIT-1:0] pat_out, pat_freq;
    logic [7:0]          low_per, high_per;
    logic [15:0]         busy_ext;
    logic                in_collect, gap_clr, gap_expire, reject;

    assign ctrl       = pack_q[0];
    assign ch         = ctrl[CTRL_CH_LSB +: CTRL_CH_W];
    assign repeat_bit = ctrl[CTRL_REPEAT_BIT];
    assign stop_bit   = ctrl[CTRL_STOP_BIT];
    assign rsv        = ctrl[CTRL_RSV_LSB +: CTRL_RSV_W];
    assign low_per    = pack_q[2*NB+1];
    assign high_per   = pack_q[2*NB+2];
    assign busy_ext   = 16'(bus.ch_busy_i);

    // Patterns arrive LSB byte first
    always_comb begin
        pat_out  = '0;
        pat_freq = '0;
        for (int i = 0; i < NB; i++) begin
            pat_out[8*i +: 8]  = pack_q[1+i];
            pat_freq[8*i +: 8] = pack_q[1+NB+i];
        end
    end

    assign reject = (rsv != 2'b00) || (int'(ch) >= CH_NUM) ||
                    (!stop_bit && ((low_per == 8'd0) || (high_per == 8'd0)));

    assign in_collect = (state_q == ST_COLLECT);
    assign gap_clr    = !in_collect || bus.rx_done_tick_i;

    pack_gap_timer #(
        .TIMEOUT_CLK (TIMEOUT_CLK)
    ) u_gap_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (gap_clr),
        .en_i     (in_collect),
        .expire_o (gap_expire)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pack_d       = pack_q;
        cfg_valid_d  = 1'b0;
        cfg_ch_d     = cfg_ch_q;
        cfg_stop_d   = cfg_stop_q;
        cfg_repeat_d = cfg_repeat_q;
        cfg_output_d = cfg_output_q;
        cfg_freq_d   = cfg_freq_q;
        cfg_low_d    = cfg_low_q;
        cfg_high_d   = cfg_high_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.rx_done_tick_i) begin
                    pack_d[0] = bus.data_i;
                    cnt_d     = CW'(1);
                    state_d   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // Expiry wins over a byte landing in the same cycle
                if (gap_expire) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = ACK_NG;
                    state_d    = ST_ACK;
                end else if (bus.rx_done_tick_i) begin
                    pack_d[cnt_q] = bus.data_i;
                    cnt_d         = cnt_q + 1'b1;
                    if (int'(cnt_q) + 1 == PACK_NUM) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (reject) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = ACK_NG;
                    state_d    = ST_ACK;
                end else begin
                    state_d = ST_WAIT_CH;
                end
            end
            ST_WAIT_CH: begin
                if (stop_bit || !busy_ext[ch]) begin
                    cfg_valid_d  = 1'b1;
                    cfg_ch_d     = ch;
                    cfg_stop_d   = stop_bit;
                    cfg_repeat_d = repeat_bit;
                    cfg_output_d = pat_out;
                    cfg_freq_d   = pat_freq;
                    cfg_low_d    = low_per;
                    cfg_high_d   = high_per;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tx_start_d = 1'b1;
                tx_data_d  = ACK_OK;
                state_d    = ST_ACK;
            end
            ST_ACK: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            for (int i = 0; i < PACK_NUM; i++) begin
                pack_q[i] <= '0;
            end
            cfg_valid_q  <= 1'b0;
            cfg_ch_q     <= '0;
            cfg_stop_q   <= 1'b0;
            cfg_repeat_q <= 1'b0;
            cfg_output_q <= '0;
            cfg_freq_q   <= '0;
            cfg_low_q    <= '0;
            cfg_high_q   <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pack_q       <= pack_d;
            cfg_valid_q  <= cfg_valid_d;
            cfg_ch_q     <= cfg_ch_d;
            cfg_stop_q   <= cfg_stop_d;
            cfg_repeat_q <= cfg_repeat_d;
            cfg_output_q <= cfg_output_d;
            cfg_freq_q   <= cfg_freq_d;
            cfg_low_q    <= cfg_low_d;
            cfg_high_q   <= cfg_high_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
        end
    end

    assign bus.cfg_valid_o  = cfg_valid_q;
    assign bus.cfg_ch_o     = cfg_ch_q;
    assign bus.cfg_stop_o   = cfg_stop_q;
    assign bus.cfg_repeat_o = cfg_repeat_q;
    assign bus.cfg_output_o = cfg_output_q;
    assign bus.cfg_freq_o   = cfg_freq_q;
    assign bus.cfg_low_o    = cfg_low_q;
    assign bus.cfg_high_o   = cfg_high_q;
    assign bus.tx_start_o   = tx_start_q;
    assign bus.tx_data_o    = tx_data_q;
    assign bus.busy_o       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_pack_cmd_ctrl.sv
// Directed bench for pack_cmd_ctrl: table of packs with hand-computed results
// plus hand-written busy-wait, timeout and mid-pack reset sequences.
module tb_pack_cmd_ctrl;
    localparam int DATA_BIT    = 32;
    localparam int CH_NUM      = 16;
    localparam int TIMEOUT_CLK = 200;
    localparam int PN          = 11;

    typedef logic [PN-1:0][7:0] pk_t;

    typedef struct {
        pk_t         pk;
        logic [15:0] busy;
        logic        acc;
        logic [7:0]  ack;
        logic [3:0]  ch;
        logic        stop;
        logic        rep;
        logic [31:0] outp;
        logic [31:0] freq;
        logic [7:0]  low;
        logic [7:0]  high;
    } vec_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    pack_cmd_ctrl_if #(.DATA_BIT(DATA_BIT), .CH_NUM(CH_NUM)) bus ();

    pack_cmd_ctrl #(
        .DATA_BIT    (DATA_BIT),
        .CH_NUM      (CH_NUM),
        .TIMEOUT_CLK (TIMEOUT_CLK)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int n_chk = 0, n_fail = 0;
    int n_cfg = 0, n_tx = 0, cfg_cyc = -1, tx_cyc = -1, last_tick = 0;
    logic [7:0] tx_byte = 8'h00;

    logic [3:0]  m_ch   = '0;
    logic        m_stop = 1'b0, m_rep = 1'b0;
    logic [31:0] m_out  = '0, m_freq = '0;
    logic [7:0]  m_low  = '0, m_high = '0;

    always @(negedge clk_i) begin
        if (bus.cfg_valid_o) begin
            n_cfg++;
            cfg_cyc = cyc;
        end
        if (bus.tx_start_o) begin
            n_tx++;
            tx_cyc  = cyc;
            tx_byte = bus.tx_data_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic pk_t mk(input logic [7:0] c, input logic [31:0] o, input logic [31:0] f,
                               input logic [7:0] lo, input logic [7:0] hi);
        pk_t p;
        p[0] = c;
        for (int i = 0; i < 4; i++) begin
            p[1+i] = o[8*i +: 8];
            p[5+i] = f[8*i +: 8];
        end
        p[9]  = lo;
        p[10] = hi;
        return p;
    endfunction

    function automatic vec_t setv(input pk_t p, input logic [15:0] b, input logic a, input logic [7:0] k,
                                  input logic [3:0] c, input logic s, input logic r, input logic [31:0] o,
                                  input logic [31:0] f, input logic [7:0] lo, input logic [7:0] hi);
        vec_t v;
        v.pk = p; v.busy = b; v.acc = a; v.ack = k; v.ch = c; v.stop = s; v.rep = r;
        v.outp = o; v.freq = f; v.low = lo; v.high = hi;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_i); #1;
        bus.data_i         = b;
        bus.rx_done_tick_i = 1'b1;
        last_tick          = cyc;
    endtask

    task automatic tick_off();
        @(posedge clk_i); #1;
        bus.rx_done_tick_i = 1'b0;
    endtask

    task automatic send_pack(input pk_t p, input int n);
        for (int i = 0; i < n; i++) send_byte(p[i]);
        tick_off();
    endtask

    task automatic wait_tx(input string nm, input int t0, input int budget);
        int k = 0;
        while (n_tx == t0 && k < budget) begin
            @(posedge clk_i);
            k++;
        end
        if (n_tx == t0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_ack_timeout: no tx_start_o within %0d cycles", nm, budget);
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic chk_fields(input string nm);
        chk({nm, "_ch"},     32'(bus.cfg_ch_o),     32'(m_ch));
        chk({nm, "_stop"},   32'(bus.cfg_stop_o),   32'(m_stop));
        chk({nm, "_repeat"}, 32'(bus.cfg_repeat_o), 32'(m_rep));
        chk({nm, "_output"}, bus.cfg_output_o,      m_out);
        chk({nm, "_freq"},   bus.cfg_freq_o,        m_freq);
        chk({nm, "_low"},    32'(bus.cfg_low_o),    32'(m_low));
        chk({nm, "_high"},   32'(bus.cfg_high_o),   32'(m_high));
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        int c0 = n_cfg;
        int t0 = n_tx;
        bus.ch_busy_i = v.busy;
        send_pack(v.pk, PN);
        wait_tx(nm, t0, 40);
        chk({nm, "_cfg_count"}, 32'(n_cfg - c0), v.acc ? 32'd1 : 32'd0);
        chk({nm, "_tx_count"},  32'(n_tx - t0), 32'd1);
        chk({nm, "_ack"},       32'(tx_byte),    32'(v.ack));
        chk({nm, "_busy_o"},    32'(bus.busy_o), 32'd0);
        if (v.acc) begin
            chk({nm, "_latency"}, 32'(cfg_cyc - last_tick), 32'd3);
            m_ch = v.ch; m_stop = v.stop; m_rep = v.rep;
            m_out = v.outp; m_freq = v.freq; m_low = v.low; m_high = v.high;
        end
        chk_fields(nm);
        bus.ch_busy_i = '0;
    endtask

    vec_t tv [9];

    initial begin
        int c0, t0, fall, k;
        pk_t partial;

        bus.data_i         = 8'h00;
        bus.rx_done_tick_i = 1'b0;
        bus.ch_busy_i      = '0;

        tv[0] = setv({8'h05, 8'h14, 8'h00, 8'h00, 8'hF0, 8'hF0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h03},
                     16'h0000, 1'b1, 8'h06, 4'h3, 1'b0, 1'b0, 32'h12345678, 32'h0000F0F0, 8'd20, 8'd5);
        tv[1] = setv(mk(8'hC1, 32'h11111111, 32'h22222222, 8'd1, 8'd1),
                     16'h0000, 1'b0, 8'h15, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'd0, 8'd0);
        tv[2] = setv(mk(8'h1A, 32'hAABBCCDD, 32'h01020304, 8'h01, 8'hFF),
                     16'h0008, 1'b1, 8'h06, 4'hA, 1'b0, 1'b1, 32'hAABBCCDD, 32'h01020304, 8'h01, 8'hFF);
        tv[3] = setv(mk(8'h07, 32'h33333333, 32'h44444444, 8'h00, 8'h05),
                     16'h0000, 1'b0, 8'h15, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'd0, 8'd0);
        tv[4] = setv(mk(8'h07, 32'h55555555, 32'h66666666, 8'h05, 8'h00),
                     16'h0000, 1'b0, 8'h15, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'd0, 8'd0);
        tv[5] = setv(mk(8'h22, 32'hCAFEBABE, 32'h00000000, 8'h00, 8'h00),
                     16'h0004, 1'b1, 8'h06, 4'h2, 1'b1, 1'b0, 32'hCAFEBABE, 32'h00000000, 8'h00, 8'h00);
        tv[6] = setv(mk(8'h81, 32'h77777777, 32'h88888888, 8'd3, 8'd3),
                     16'h0000, 1'b0, 8'h15, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'd0, 8'd0);
        tv[7] = setv(mk(8'h10, 32'h00000001, 32'h80000000, 8'h02, 8'h03),
                     16'h0000, 1'b1, 8'h06, 4'h0, 1'b0, 1'b1, 32'h00000001, 32'h80000000, 8'h02, 8'h03);
        tv[8] = setv(mk(8'h3F, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 8'h00),
                     16'h8000, 1'b1, 8'h06, 4'hF, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 8'h00);

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_cfg_valid", 32'(bus.cfg_valid_o), 32'd0);
        chk("rst_tx_start",  32'(bus.tx_start_o),  32'd0);
        chk("rst_tx_data",   32'(bus.tx_data_o),   32'd0);
        chk("rst_busy",      32'(bus.busy_o),      32'd0);
        chk_fields("rst");
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 9; i++) apply_vec(tv[i], $sformatf("vec%0d", i));

        // Target channel busy for 50 cycles after the pack completes
        c0 = n_cfg;
        t0 = n_tx;
        bus.ch_busy_i = 16'h0008;
        send_pack(tv[0].pk, PN);
        repeat (50) @(posedge clk_i);
        #1;
        chk("busy_hold_no_cfg", 32'(n_cfg - c0), 32'd0);
        chk("busy_hold_busy_o", 32'(bus.busy_o), 32'd1);
        bus.ch_busy_i = '0;
        fall = cyc;
        wait_tx("busy_release", t0, 20);
        chk("busy_release_cycle", 32'(cfg_cyc), 32'(fall + 1));
        chk("busy_release_cfg_count", 32'(n_cfg - c0), 32'd1);
        chk("busy_release_ack", 32'(tx_byte), 32'h06);
        m_ch = 4'h3; m_stop = 1'b0; m_rep = 1'b0;
        m_out = 32'h12345678; m_freq = 32'h0000F0F0; m_low = 8'd20; m_high = 8'd5;
        chk_fields("busy_release");

        // Gap timeout after 5 bytes
        c0 = n_cfg;
        t0 = n_tx;
        send_pack(tv[2].pk, 5);
        wait_tx("timeout", t0, TIMEOUT_CLK + 30);
        chk("timeout_cycle", 32'(tx_cyc - last_tick), 32'(TIMEOUT_CLK + 1));
        chk("timeout_ack", 32'(tx_byte), 32'h15);
        chk("timeout_no_cfg", 32'(n_cfg - c0), 32'd0);
        chk_fields("timeout");
        apply_vec(tv[0], "after_timeout");

        // A byte landing in the expiry cycle still times out and is dropped
        c0 = n_cfg;
        t0 = n_tx;
        send_pack(tv[7].pk, 5);
        k = 0;
        while (cyc != last_tick + TIMEOUT_CLK && k < TIMEOUT_CLK + 10) begin
            @(posedge clk_i); #1;
            k++;
        end
        bus.data_i = 8'h55;
        bus.rx_done_tick_i = 1'b1;
        fall = cyc;
        tick_off();
        wait_tx("expire_tick", t0, 20);
        chk("expire_tick_cycle", 32'(tx_cyc), 32'(fall + 1));
        chk("expire_tick_ack", 32'(tx_byte), 32'h15);
        chk("expire_tick_no_cfg", 32'(n_cfg - c0), 32'd0);
        apply_vec(tv[2], "after_expire_tick");

        // Reset after 6 bytes of a pack
        partial = mk(8'h05, 32'hDEADBEEF, 32'h0BADF00D, 8'h09, 8'h09);
        send_pack(partial, 6);
        rst_ni = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy_o), 32'd0);
        chk("midrst_output", bus.cfg_output_o, 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_ch = '0; m_stop = 1'b0; m_rep = 1'b0; m_out = '0; m_freq = '0; m_low = '0; m_high = '0;
        c0 = n_cfg;
        t0 = n_tx;
        apply_vec(tv[7], "after_midrst");
        repeat (40) @(posedge clk_i);
        #1;
        chk("after_midrst_total_cfg", 32'(n_cfg - c0), 32'd1);
        chk("after_midrst_total_tx",  32'(n_tx - t0),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
